// File: rtl/nonce_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : nonce_feeder_if
// Purpose  : Bundles the job-launch inputs and the message/status outputs of
//            the nonce feeder into one interface.
// Modports :
//   master - job source side (drives start/Hin/tail/nonce range/found,
//            observes en/nonce/M/H/busy/done/exhausted)
//   slave  - nonce feeder side (the reverse directions)
// Signals  :
//   start        job launch pulse
//   Hin[255:0]   midstate for the job
//   tail[95:0]   header bytes 64..75, word0 in [95:64]
//   nonce_start  first nonce of the range
//   nonce_end    last nonce of the range, inclusive
//   found        downstream hit, aborts a running job
//   en           one-cycle strobe per issued message
//   nonce        nonce carried by the current en beat
//   M[511:0]     padded second-chunk message block, word0 = MSB
//   H[255:0]     latched midstate
//   busy         high while a range is being issued
//   done         one-cycle end-of-run pulse
//   exhausted    qualifies done: 1 = whole range issued, 0 = aborted
// Revision : 1.0 - initial release
// ============================================================================
interface nonce_feeder_if;

  localparam int c_WORD_S = 32;
  localparam int c_MSG_S  = 512;
  localparam int c_H_SIZE = 256;
  localparam int c_TAIL_S = 3 * c_WORD_S;

  // Job side
  logic                start;
  logic [c_H_SIZE-1:0] Hin;
  logic [c_TAIL_S-1:0] tail;
  logic [c_WORD_S-1:0] nonce_start;
  logic [c_WORD_S-1:0] nonce_end;
  logic                found;

  // Pipeline side
  logic                en;
  logic [c_WORD_S-1:0] nonce;
  logic [c_MSG_S-1:0]  M;
  logic [c_H_SIZE-1:0] H;
  logic                busy;
  logic                done;
  logic                exhausted;

  modport master (
    output start, Hin, tail, nonce_start, nonce_end, found,
    input  en, nonce, M, H, busy, done, exhausted
  );

  modport slave (
    input  start, Hin, tail, nonce_start, nonce_end, found,
    output en, nonce, M, H, busy, done, exhausted
  );

endinterface
`default_nettype wire

// File: rtl/nonce_feeder.sv
`default_nettype none
// ============================================================================
// Module   : nonce_feeder
// Purpose  : Work dispatcher in front of the W-schedule entry stage of the
//            miner pipeline. Accepts one job (midstate, 96-bit header tail,
//            inclusive nonce range) and emits one fully padded 512-bit
//            second-chunk message block per clock, each carrying the next
//            nonce, until the range is exhausted or the downstream
//            comparator reports a hit on found.
// Ports    :
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   feed   slave modport of nonce_feeder_if (job inputs, message outputs,
//          busy/done/exhausted status)
// Options  :
//   NONCE_BSWAP_EN  when defined, word 3 of M carries the byte-swapped
//                   nonce (little-endian header serialization); the nonce
//                   output itself is never swapped.
// Timing   : every output is registered; start sampled at edge k gives the
//            first en beat in cycle k+1 and N beats back to back.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_feeder (
  input  logic          clk,
  input  logic          reset,
  nonce_feeder_if.slave feed
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_WORD_S = 32;
  localparam int c_MSG_S  = 512;
  localparam int c_H_SIZE = 256;
  localparam int c_TAIL_S = 3 * c_WORD_S;

  // Padding for a 640-bit message: a single 1 bit after the nonce, zeros,
  // then the bit length in the last word.
  localparam logic [c_WORD_S-1:0]     c_PAD_WORD = 32'h8000_0000;
  localparam logic [c_WORD_S-1:0]     c_LEN_WORD = 32'h0000_0280;
  localparam logic [10*c_WORD_S-1:0]  c_ZERO_WORDS = '0;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  logic [0:0]          state_q,  state_d;
  logic [c_WORD_S-1:0] cur_q,    cur_d;     // next nonce to issue
  logic [c_WORD_S-1:0] nend_q,   nend_d;    // latched inclusive end
  logic                en_q,     en_d;
  logic [c_WORD_S-1:0] nonce_q,  nonce_d;   // last issued nonce
  logic [c_MSG_S-1:0]  m_q,      m_d;
  logic [c_H_SIZE-1:0] h_q,      h_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic                exh_q,    exh_d;

  // Range end is reached when the nonce already on the bus is the last one.
  logic                w_last_issued;
  logic [c_TAIL_S-1:0] w_tail_held;

  assign w_last_issued = (nonce_q == nend_q);

  // The tail is not kept in a separate register: words 0..2 of the message
  // register hold it unchanged for the whole run, so they are reused.
  assign w_tail_held = m_q[c_MSG_S-1 -: c_TAIL_S];

  // --------------------------------------------------------------------------
  // Message construction helpers
  // --------------------------------------------------------------------------
  function automatic logic [c_WORD_S-1:0] f_nonce_word(
    input logic [c_WORD_S-1:0] n
  );
`ifdef NONCE_BSWAP_EN
    f_nonce_word = {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    f_nonce_word = n;
`endif
  endfunction

  // Word layout: 0..2 tail, 3 nonce, 4 pad marker, 5..14 zero, 15 length.
  function automatic logic [c_MSG_S-1:0] f_build_msg(
    input logic [c_TAIL_S-1:0] tail_v,
    input logic [c_WORD_S-1:0] n
  );
    f_build_msg = {tail_v, f_nonce_word(n), c_PAD_WORD, c_ZERO_WORDS, c_LEN_WORD};
  endfunction

  // --------------------------------------------------------------------------
  // Process 1: state and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
      cur_q   <= '0;
      nend_q  <= '0;
      en_q    <= 1'b0;
      nonce_q <= '0;
      m_q     <= '0;
      h_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nend_q  <= nend_d;
      en_q    <= en_d;
      nonce_q <= nonce_d;
      m_q     <= m_d;
      h_q     <= h_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exh_q   <= exh_d;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (feed.start) begin
          state_d = c_ST_RUN;
        end
      end
      c_ST_RUN: begin
        if (feed.found || w_last_issued) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Process 3: output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    en_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d == c_ST_RUN);
    cur_d   = cur_q;
    nend_d  = nend_q;
    nonce_d = nonce_q;
    m_d     = m_q;
    h_d     = h_q;
    exh_d   = exh_q;

    case (state_q)
      c_ST_IDLE: begin
        // Launch: the first beat goes out on the same edge that samples
        // start, so nonce_start bypasses the cur register.
        if (feed.start) begin
          en_d    = 1'b1;
          nonce_d = feed.nonce_start;
          m_d     = f_build_msg(feed.tail, feed.nonce_start);
          h_d     = feed.Hin;
          nend_d  = feed.nonce_end;
          cur_d   = feed.nonce_start + 32'd1;
          exh_d   = 1'b0;
        end
      end
      c_ST_RUN: begin
        // found wins over exhaustion when both land on the same edge.
        if (feed.found) begin
          done_d = 1'b1;
          exh_d  = 1'b0;
        end else if (w_last_issued) begin
          done_d = 1'b1;
          exh_d  = 1'b1;
        end else begin
          en_d    = 1'b1;
          nonce_d = cur_q;
          m_d     = f_build_msg(w_tail_held, cur_q);
          cur_d   = cur_q + 32'd1;   // wraps modulo 2^32
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign feed.en        = en_q;
  assign feed.nonce     = nonce_q;
  assign feed.M         = m_q;
  assign feed.H         = h_q;
  assign feed.busy      = busy_q;
  assign feed.done      = done_q;
  assign feed.exhausted = exh_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_feeder
// Purpose  : Directed self-checking bench for nonce_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_feeder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  nonce_feeder_if u_if ();

  nonce_feeder u_dut (
    .clk   (clk),
    .reset (reset),
    .feed  (u_if.slave)
  );

  always #5 clk = ~clk;

  localparam logic [95:0]  c_TAIL_A = 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4;
  localparam logic [95:0]  c_TAIL_B = 96'h0F1E2D3C_4B5A6978_8796A5B4;
  localparam logic [255:0] c_H_A =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] c_H_B =
    256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_cafef00d_0badc0de_55aa55aa;

  function automatic logic [31:0] exp_w3(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    exp_w3 = {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    exp_w3 = n;
`endif
  endfunction

  function automatic logic [511:0] exp_msg(input logic [95:0] t, input logic [31:0] n);
    exp_msg = {t, exp_w3(n), 32'h80000000, 320'd0, 32'h00000280};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e,
                        input logic [95:0] t, input logic [255:0] h);
    u_if.tail        = t;
    u_if.Hin         = h;
    u_if.nonce_start = s;
    u_if.nonce_end   = e;
    u_if.start       = 1'b1;
    tick();
    u_if.start       = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (u_if.en !== 1'b0)    begin errors++; $display("FAIL reset_en: got %b want 0", u_if.en); end
    checks++; if (u_if.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b0) begin errors++; $display("FAIL reset_exh: got %b want 0", u_if.exhausted); end
    checks++; if (u_if.nonce !== 32'd0) begin errors++; $display("FAIL reset_nonce: got %h want 0", u_if.nonce); end
    checks++; if (u_if.M !== 512'd0)   begin errors++; $display("FAIL reset_M: got %h want 0", u_if.M); end
    checks++; if (u_if.H !== 256'd0)   begin errors++; $display("FAIL reset_H: got %h want 0", u_if.H); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [31:0] n;
    launch(32'd5, 32'd8, c_TAIL_A, c_H_A);
    for (int i = 0; i < 4; i++) begin
      n = 32'd5 + 32'(i);
      checks++; if (u_if.en !== 1'b1)   begin errors++; $display("FAIL basic_en beat %0d: got %b want 1", i, u_if.en); end
      checks++; if (u_if.nonce !== n)   begin errors++; $display("FAIL basic_nonce beat %0d: got %h want %h", i, u_if.nonce, n); end
      checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy beat %0d: got %b want 1", i, u_if.busy); end
      checks++; if (u_if.M !== exp_msg(c_TAIL_A, n)) begin errors++; $display("FAIL basic_M beat %0d: got %h want %h", i, u_if.M, exp_msg(c_TAIL_A, n)); end
      if (i == 0) begin
        checks++; if (u_if.M[383:352] !== 32'h80000000) begin errors++; $display("FAIL basic_word4: got %h want 80000000", u_if.M[383:352]); end
        checks++; if (u_if.M[31:0] !== 32'h00000280)    begin errors++; $display("FAIL basic_word15: got %h want 00000280", u_if.M[31:0]); end
        checks++; if (u_if.H !== c_H_A) begin errors++; $display("FAIL basic_H: got %h want %h", u_if.H, c_H_A); end
      end
      tick();
    end
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL basic_end_en: got %b want 0", u_if.en); end
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b1) begin errors++; $display("FAIL basic_exh: got %b want 1", u_if.exhausted); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL basic_end_busy: got %b want 0", u_if.busy); end
    tick();
    checks++; if (u_if.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b1) begin errors++; $display("FAIL basic_exh_hold: got %b want 1", u_if.exhausted); end
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL basic_idle_en: got %b want 0", u_if.en); end
  endtask

  task automatic test_single;
    launch(32'h1234, 32'h1234, c_TAIL_B, c_H_B);
    checks++; if (u_if.en !== 1'b1)       begin errors++; $display("FAIL single_en: got %b want 1", u_if.en); end
    checks++; if (u_if.nonce !== 32'h1234) begin errors++; $display("FAIL single_nonce: got %h want 1234", u_if.nonce); end
    tick();
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL single_end_en: got %b want 0", u_if.en); end
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b1) begin errors++; $display("FAIL single_exh: got %b want 1", u_if.exhausted); end
  endtask

  // Called while done of the previous run is high: start must be taken.
  task automatic test_back_to_back;
    launch(32'd7, 32'd8, c_TAIL_A, c_H_A);
    checks++; if (u_if.en !== 1'b1)    begin errors++; $display("FAIL b2b_en: got %b want 1", u_if.en); end
    checks++; if (u_if.nonce !== 32'd7) begin errors++; $display("FAIL b2b_nonce0: got %h want 7", u_if.nonce); end
    checks++; if (u_if.exhausted !== 1'b0) begin errors++; $display("FAIL b2b_exh_clear: got %b want 0", u_if.exhausted); end
    checks++; if (u_if.done !== 1'b0)  begin errors++; $display("FAIL b2b_done: got %b want 0", u_if.done); end
    tick();
    checks++; if (u_if.nonce !== 32'd8) begin errors++; $display("FAIL b2b_nonce1: got %h want 8", u_if.nonce); end
    tick();
    checks++; if (u_if.done !== 1'b1)  begin errors++; $display("FAIL b2b_end_done: got %b want 1", u_if.done); end
    tick();
  endtask

  task automatic test_wrap;
    logic [31:0] n;
    launch(32'hFFFFFFFE, 32'h00000001, c_TAIL_B, c_H_B);
    for (int i = 0; i < 4; i++) begin
      n = 32'hFFFFFFFE + 32'(i);
      checks++; if (u_if.en !== 1'b1) begin errors++; $display("FAIL wrap_en beat %0d: got %b want 1", i, u_if.en); end
      checks++; if (u_if.nonce !== n) begin errors++; $display("FAIL wrap_nonce beat %0d: got %h want %h", i, u_if.nonce, n); end
      tick();
    end
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL wrap_end_en: got %b want 0", u_if.en); end
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b1) begin errors++; $display("FAIL wrap_exh: got %b want 1", u_if.exhausted); end
    tick();
  endtask

  task automatic test_abort;
    logic [31:0] n;
    launch(32'd0, 32'hFFFFFFFF, c_TAIL_A, c_H_A);
    for (int i = 0; i < 10; i++) begin
      n = 32'(i);
      checks++; if (u_if.en !== 1'b1) begin errors++; $display("FAIL abort_en beat %0d: got %b want 1", i, u_if.en); end
      checks++; if (u_if.M !== exp_msg(c_TAIL_A, n)) begin errors++; $display("FAIL abort_M beat %0d: got %h want %h", i, u_if.M, exp_msg(c_TAIL_A, n)); end
      if (i == 4) begin
        u_if.start = 1'b1; u_if.nonce_start = 32'd555; u_if.Hin = c_H_B; u_if.tail = c_TAIL_B;
      end else begin
        u_if.start = 1'b0;
      end
      if (i == 9) u_if.found = 1'b1;
      tick();
    end
    u_if.found = 1'b0;
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL abort_end_en: got %b want 0", u_if.en); end
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b0) begin errors++; $display("FAIL abort_exh: got %b want 0", u_if.exhausted); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.H !== c_H_A)   begin errors++; $display("FAIL abort_H: got %h want %h", u_if.H, c_H_A); end
    tick();
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL abort_after_en: got %b want 0", u_if.en); end
  endtask

  task automatic test_found_at_end;
    launch(32'd10, 32'd12, c_TAIL_B, c_H_B);
    for (int i = 0; i < 3; i++) begin
      checks++; if (u_if.nonce !== 32'd10 + 32'(i)) begin errors++; $display("FAIL tie_nonce beat %0d: got %h want %h", i, u_if.nonce, 32'd10 + 32'(i)); end
      if (i == 2) u_if.found = 1'b1;
      tick();
    end
    u_if.found = 1'b0;
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL tie_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b0) begin errors++; $display("FAIL tie_exh: got %b want 0", u_if.exhausted); end
    tick();
  endtask

  task automatic test_found_idle;
    u_if.found = 1'b1;
    tick();
    u_if.found = 1'b0;
    checks++; if (u_if.done !== 1'b0) begin errors++; $display("FAIL idle_found_done: got %b want 0", u_if.done); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL idle_found_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.en !== 1'b0)   begin errors++; $display("FAIL idle_found_en: got %b want 0", u_if.en); end
  endtask

  task automatic test_reset_midrun;
    launch(32'd0, 32'd100, c_TAIL_A, c_H_A);
    tick();
    tick();
    checks++; if (u_if.nonce !== 32'd2) begin errors++; $display("FAIL rst_mid_beat3: got %h want 2", u_if.nonce); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (u_if.en !== 1'b0)    begin errors++; $display("FAIL rst_mid_en: got %b want 0", u_if.en); end
    checks++; if (u_if.busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.nonce !== 32'd0) begin errors++; $display("FAIL rst_mid_nonce: got %h want 0", u_if.nonce); end
    checks++; if (u_if.M !== 512'd0)   begin errors++; $display("FAIL rst_mid_M: got %h want 0", u_if.M); end
    checks++; if (u_if.H !== 256'd0)   begin errors++; $display("FAIL rst_mid_H: got %h want 0", u_if.H); end
    tick();
    checks++; if (u_if.en !== 1'b0)    begin errors++; $display("FAIL rst_mid_no_en: got %b want 0", u_if.en); end
    launch(32'd200, 32'd202, c_TAIL_B, c_H_B);
    for (int i = 0; i < 3; i++) begin
      checks++; if (u_if.en !== 1'b1) begin errors++; $display("FAIL rst_restart_en beat %0d: got %b want 1", i, u_if.en); end
      checks++; if (u_if.M !== exp_msg(c_TAIL_B, 32'd200 + 32'(i))) begin errors++; $display("FAIL rst_restart_M beat %0d: got %h want %h", i, u_if.M, exp_msg(c_TAIL_B, 32'd200 + 32'(i))); end
      tick();
    end
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL rst_restart_done: got %b want 1", u_if.done); end
    checks++; if (u_if.exhausted !== 1'b1) begin errors++; $display("FAIL rst_restart_exh: got %b want 1", u_if.exhausted); end
    tick();
  endtask

  task automatic test_bswap;
    logic [31:0] w3;
`ifdef NONCE_BSWAP_EN
    w3 = 32'h44332211;
`else
    w3 = 32'h11223344;
`endif
    launch(32'h11223344, 32'h11223344, c_TAIL_A, c_H_A);
    checks++; if (u_if.nonce !== 32'h11223344) begin errors++; $display("FAIL bswap_nonce: got %h want 11223344", u_if.nonce); end
    checks++; if (u_if.M[415:384] !== w3) begin errors++; $display("FAIL bswap_word3: got %h want %h", u_if.M[415:384], w3); end
    tick();
    checks++; if (u_if.done !== 1'b1) begin errors++; $display("FAIL bswap_done: got %b want 1", u_if.done); end
    tick();
  endtask

  initial begin
    u_if.start       = 1'b0;
    u_if.found       = 1'b0;
    u_if.Hin         = '0;
    u_if.tail        = '0;
    u_if.nonce_start = '0;
    u_if.nonce_end   = '0;
    test_reset();
    test_basic();
    test_single();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_found_at_end();
    test_found_idle();
    test_reset_midrun();
    test_bswap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
